// File: rtl/fir_phase_seq_pkg.sv
// Shared types and constants for the FIR tap-phase sequencer.
// Phase code PH_CLR is the accumulator-clear phase in the downstream control decoder.
package fir_phase_seq_pkg;
    localparam int PHASE_W = 4;
    localparam logic [PHASE_W-1:0] PH_CLR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fir_wrap_cnt.sv
// Generic wrapping counter: counts 0..MAX on i_en, o_wrap flags the step that returns to 0.
// Latency: count updates one edge after i_en; o_wrap is combinational; i_clr has priority.
module fir_wrap_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);
    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && (r_cnt == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fir_phase_seq.sv
// Tap-phase sequencer: steps phase per accepted operand, tracks col/row, start/busy/done to host.
// Latency: start -> in_ready 1 cycle; last accept -> frame_done 1 cycle. Stalls hold all counters.
module fir_phase_seq
    import fir_phase_seq_pkg::*;
#(
    parameter int PHASE_MAX = 8,
    parameter int IMG_W     = 16,
    parameter int IMG_H     = 16,
    parameter int COL_W     = 8,
    parameter int ROW_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PHASE_W-1:0] phase,
    output logic [COL_W-1:0]   col,
    output logic [ROW_W-1:0]   row,
    output logic               busy,
    output logic               sample_done,
    output logic               frame_done
);
    state_t             r_state;
    logic               r_sample_done;
    logic               r_frame_done;
    logic               w_accept;
    logic               w_ph_en;
    logic               w_ph_wrap;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic [PHASE_W-1:0] w_phase;

    assign in_ready    = (r_state == ST_RUN);
    assign busy        = (r_state != ST_IDLE);
    assign sample_done = r_sample_done;
    assign frame_done  = r_frame_done;
    assign w_accept    = in_valid && in_ready;
    // Abort gates the enable so no wrap flag, and therefore no pulse, can escape.
    assign w_ph_en     = w_accept && !abort;
    assign phase       = (r_state == ST_RUN) ? w_phase : PH_CLR;

    fir_wrap_cnt #(.W(PHASE_W), .MAX(PHASE_MAX)) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (abort),
        .i_en   (w_ph_en),
        .o_cnt  (w_phase),
        .o_wrap (w_ph_wrap)
    );

    fir_wrap_cnt #(.W(COL_W), .MAX(IMG_W - 1)) u_col_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (abort),
        .i_en   (w_ph_wrap),
        .o_cnt  (col),
        .o_wrap (w_col_wrap)
    );

    fir_wrap_cnt #(.W(ROW_W), .MAX(IMG_H - 1)) u_row_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (abort),
        .i_en   (w_col_wrap),
        .o_cnt  (row),
        .o_wrap (w_row_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sample_done <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_sample_done <= w_ph_wrap;
            r_frame_done  <= w_row_wrap;
            if (abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (start) r_state <= ST_RUN;
                    ST_RUN:  if (w_row_wrap) r_state <= ST_DONE;
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fir_phase_seq.sv
// Directed bench for fir_phase_seq: default 9x16x16 instance plus a small 3x2x2 instance.
module tb_fir_phase_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       d_start = 1'b0, d_abort = 1'b0, d_in_valid = 1'b0;
    logic       d_in_ready, d_busy, d_sample_done, d_frame_done;
    logic [3:0] d_phase;
    logic [7:0] d_col, d_row;

    logic       s_start = 1'b0, s_abort = 1'b0, s_in_valid = 1'b0;
    logic       s_in_ready, s_busy, s_sample_done, s_frame_done;
    logic [3:0] s_phase;
    logic [7:0] s_col, s_row;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_phase_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .phase(d_phase),
        .col(d_col), .row(d_row), .busy(d_busy),
        .sample_done(d_sample_done), .frame_done(d_frame_done)
    );

    fir_phase_seq #(.PHASE_MAX(2), .IMG_W(2), .IMG_H(2), .COL_W(8), .ROW_W(8)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .phase(s_phase),
        .col(s_col), .row(s_row), .busy(s_busy),
        .sample_done(s_sample_done), .frame_done(s_frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_go();
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
    endtask

    task automatic s_go();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic d_run(input int n);
        d_in_valid = 1'b1;
        repeat (n) tick();
        d_in_valid = 1'b0;
    endtask

    task automatic d_do_abort();
        d_abort = 1'b1;
        tick();
        d_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (d_phase !== 4'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", d_phase); end
        checks++; if (d_col !== 8'd0 || d_row !== 8'd0) begin errors++; $display("FAIL reset_colrow got=%0d/%0d exp=0/0", d_col, d_row); end
        checks++; if (d_in_ready !== 1'b0 || d_busy !== 1'b0) begin errors++; $display("FAIL reset_rdy_busy got=%b/%b exp=0/0", d_in_ready, d_busy); end
        checks++; if (d_sample_done !== 1'b0 || d_frame_done !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b/%b exp=0/0", d_sample_done, d_frame_done); end
        checks++; if (s_busy !== 1'b0 || s_phase !== 4'd0) begin errors++; $display("FAIL reset_small got busy=%b phase=%0d exp=0/0", s_busy, s_phase); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        d_go();
        d_run(32);
        checks++; if (d_phase !== 4'd5 || d_col !== 8'd3) begin errors++; $display("FAIL pre_reset_pos got phase=%0d col=%0d exp=5/3", d_phase, d_col); end
        rst_n = 1'b0;
        #1;
        checks++; if (d_phase !== 4'd0 || d_col !== 8'd0) begin errors++; $display("FAIL async_reset_cnt got phase=%0d col=%0d exp=0/0", d_phase, d_col); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", d_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_small_frame();
        int acc = 0, sd = 0, fd = 0, first = -1;
        s_in_valid = 1'b1;
        s_go();
        for (int k = 0; k < 16; k++) begin
            if (k < 12) begin
                checks++; if (s_phase !== 4'(k % 3)) begin errors++; $display("FAIL small_phase k=%0d got=%0d exp=%0d", k, s_phase, k % 3); end
            end
            if (k == 3) begin
                checks++; if (s_col !== 8'd1 || s_row !== 8'd0) begin errors++; $display("FAIL small_col got col=%0d row=%0d exp=1/0", s_col, s_row); end
            end
            if (k == 6) begin
                checks++; if (s_col !== 8'd0 || s_row !== 8'd1) begin errors++; $display("FAIL small_rowwrap got col=%0d row=%0d exp=0/1", s_col, s_row); end
            end
            if (k == 12) begin
                checks++; if (s_busy !== 1'b1 || s_in_ready !== 1'b0) begin errors++; $display("FAIL small_done_state got busy=%b rdy=%b exp=1/0", s_busy, s_in_ready); end
            end
            if (k == 13) begin
                checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL small_idle got busy=%b exp=0", s_busy); end
            end
            sd += int'(s_sample_done);
            fd += int'(s_frame_done);
            if (s_frame_done && first < 0) first = k;
            acc += int'(s_in_ready && s_in_valid);
            tick();
        end
        s_in_valid = 1'b0;
        checks++; if (acc != 12) begin errors++; $display("FAIL small_accepts got=%0d exp=12", acc); end
        checks++; if (sd != 4) begin errors++; $display("FAIL small_sample_done got=%0d exp=4", sd); end
        checks++; if (fd != 1) begin errors++; $display("FAIL small_frame_done_cnt got=%0d exp=1", fd); end
        // k counts edges after the start-sampling edge, so k=12 is the 13th cycle counting start's cycle.
        checks++; if (first != 12) begin errors++; $display("FAIL small_frame_latency got=%0d exp=12", first); end
    endtask

    task automatic test_stall();
        d_go();
        d_run(4);
        checks++; if (d_phase !== 4'd4) begin errors++; $display("FAIL stall_pre got=%0d exp=4", d_phase); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (d_phase !== 4'd4 || d_in_ready !== 1'b1 || d_sample_done !== 1'b0) begin
                errors++; $display("FAIL stall_hold i=%0d got phase=%0d rdy=%b sd=%b exp=4/1/0", i, d_phase, d_in_ready, d_sample_done);
            end
        end
        d_run(1);
        checks++; if (d_phase !== 4'd5) begin errors++; $display("FAIL stall_resume got=%0d exp=5", d_phase); end
        d_do_abort();
    endtask

    task automatic test_row_wrap();
        d_go();
        d_run(143);
        checks++; if (d_col !== 8'd15 || d_phase !== 4'd8 || d_row !== 8'd0) begin
            errors++; $display("FAIL wrap_pre got col=%0d phase=%0d row=%0d exp=15/8/0", d_col, d_phase, d_row);
        end
        d_run(1);
        checks++; if (d_col !== 8'd0 || d_row !== 8'd1 || d_phase !== 4'd0) begin
            errors++; $display("FAIL wrap_post got col=%0d row=%0d phase=%0d exp=0/1/0", d_col, d_row, d_phase);
        end
        checks++; if (d_sample_done !== 1'b1) begin errors++; $display("FAIL wrap_sample_done got=%b exp=1", d_sample_done); end
        tick();
        checks++; if (d_sample_done !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width got=%b exp=0", d_sample_done); end
    endtask

    task automatic test_abort();
        int acc = 0, sd = 0, cyc = 0;
        logic seen = 1'b0;
        d_run(3);
        checks++; if (d_phase !== 4'd3 || d_row !== 8'd1) begin errors++; $display("FAIL abort_pre got phase=%0d row=%0d exp=3/1", d_phase, d_row); end
        d_in_valid = 1'b1;
        d_do_abort();
        d_in_valid = 1'b0;
        checks++; if (d_busy !== 1'b0 || d_in_ready !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b rdy=%b exp=0/0", d_busy, d_in_ready); end
        checks++; if (d_phase !== 4'd0 || d_row !== 8'd0 || d_col !== 8'd0) begin
            errors++; $display("FAIL abort_cnt got phase=%0d row=%0d col=%0d exp=0/0/0", d_phase, d_row, d_col);
        end
        checks++; if (d_frame_done !== 1'b0 || d_sample_done !== 1'b0) begin errors++; $display("FAIL abort_pulses got fd=%b sd=%b exp=0/0", d_frame_done, d_sample_done); end
        d_go();
        d_in_valid = 1'b1;
        while (!seen && cyc < 3000) begin
            acc += int'(d_in_ready && d_in_valid);
            tick();
            cyc++;
            sd += int'(d_sample_done);
            seen = d_frame_done;
        end
        d_in_valid = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_frame_timeout got frame_done=%b after %0d cycles exp=1", seen, cyc); end
        checks++; if (acc != 2304) begin errors++; $display("FAIL full_frame_accepts got=%0d exp=2304", acc); end
        checks++; if (sd != 256) begin errors++; $display("FAIL full_frame_samples got=%0d exp=256", sd); end
        tick();
        checks++; if (d_busy !== 1'b0 || d_frame_done !== 1'b0) begin errors++; $display("FAIL full_frame_idle got busy=%b fd=%b exp=0/0", d_busy, d_frame_done); end
    endtask

    task automatic test_start_held();
        int fd = 0;
        s_start = 1'b1;
        s_in_valid = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            fd += int'(s_frame_done);
            if (k == 12) begin
                checks++; if (s_frame_done !== 1'b1) begin errors++; $display("FAIL held_done got=%b exp=1", s_frame_done); end
            end
            if (k == 13) begin
                checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL held_idle got busy=%b exp=0", s_busy); end
            end
            if (k == 14) begin
                checks++; if (s_busy !== 1'b1 || s_phase !== 4'd0) begin errors++; $display("FAIL held_restart got busy=%b phase=%0d exp=1/0", s_busy, s_phase); end
            end
            tick();
        end
        s_start = 1'b0;
        s_in_valid = 1'b0;
        checks++; if (fd != 1) begin errors++; $display("FAIL held_frame_done_cnt got=%0d exp=1", fd); end
        s_abort = 1'b1;
        tick();
        s_abort = 1'b0;
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL held_abort got busy=%b exp=0", s_busy); end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_small_frame();
        test_stall();
        test_row_wrap();
        test_abort();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
